// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory request arbiter.
// Optional build macro used by the arbiter: MEM_ARB_PERF_EN.
package mem_req_arbiter_pkg;

    localparam int MEM_ADDR_WD = 32;
    localparam int MEM_DATA_WD = 32;
    localparam int MEM_STRB_WD = 4;

    // Owner tag stored for every accepted request so the response can be routed back.
    typedef enum logic {
        ARB_ID_INST = 1'b0,
        ARB_ID_DATA = 1'b1
    } arb_id_e;

    // Increment that sticks at the given ceiling instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] ceiling);
        return (value >= ceiling) ? ceiling : value + 4'd1;
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Sram-like request/response port. The requesting side uses the master modport,
// the responding side uses the slave modport.
interface mem_req_arbiter_if;
    import mem_req_arbiter_pkg::*;

    logic                   req;
    logic                   wr;
    logic [MEM_STRB_WD-1:0] wstrb;
    logic [MEM_ADDR_WD-1:0] addr;
    logic [MEM_DATA_WD-1:0] wdata;
    logic                   addr_ok;
    logic                   data_ok;
    logic [MEM_DATA_WD-1:0] rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/mem_arb_id_fifo.sv
// In-order owner-tag FIFO: one entry per accepted, not yet answered request.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module mem_arb_id_fifo
    import mem_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  arb_id_e                push_id,
    input  logic                   pop,
    output arb_id_e                head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    arb_id_e         slots [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    // Tag storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_id;
        end
    end

    // Pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one sram-like memory port between the instruction and data requesters.
// Data normally wins arbitration; the instruction side is forced through after
// losing STARVE_LIMIT accepted cycles in a row. Responses come back in issue order
// and are steered to their owner using the tag FIFO.
// Build macro MEM_ARB_PERF_EN adds free-running accept/conflict counters.
module mem_req_arbiter
    import mem_req_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 3
) (
    input  logic               clk,
    input  logic               resetn,
    mem_req_arbiter_if.slave   inst_port,
    mem_req_arbiter_if.slave   data_port,
    mem_req_arbiter_if.master  mem_port
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]        perf_inst_acc,
    output logic [31:0]        perf_data_acc,
    output logic [31:0]        perf_conflict
`endif
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    logic                         inst_wins;
    logic                         data_wins;
    logic                         accept;
    logic                         inst_acc;
    logic                         data_acc;
    logic                         pop;
    logic                         fifo_full;
    logic                         fifo_empty;
    logic [$clog2(MAX_OUTSTANDING):0] fifo_count;
    arb_id_e                      head_id;
    arb_id_e                      push_id;
    logic [3:0]                   starve_cnt;

    // Pick the winner: data first, unless the instruction side has waited long enough.
    always_comb begin
        inst_wins = 1'b0;
        data_wins = 1'b0;
        if (inst_port.req && (!data_port.req || starve_cnt == STARVE_MAX)) begin
            inst_wins = 1'b1;
        end else if (data_port.req) begin
            data_wins = 1'b1;
        end
    end

    assign mem_port.req = resetn & (inst_port.req | data_port.req) & ~fifo_full;
    assign accept       = mem_port.req & mem_port.addr_ok;
    assign inst_acc     = accept & inst_wins;
    assign data_acc     = accept & data_wins;
    assign push_id      = inst_wins ? ARB_ID_INST : ARB_ID_DATA;
    assign pop          = mem_port.data_ok & ~fifo_empty;

    // Forward the winner's address phase; instruction fetches are always plain reads.
    always_comb begin
        mem_port.wr    = 1'b0;
        mem_port.wstrb = '0;
        mem_port.addr  = inst_port.addr;
        mem_port.wdata = inst_port.wdata;
        if (data_wins) begin
            mem_port.wr    = data_port.wr;
            mem_port.wstrb = data_port.wstrb;
            mem_port.addr  = data_port.addr;
            mem_port.wdata = data_port.wdata;
        end
    end

    // Handshake returns: address acceptance to the winner, responses to the tagged owner.
    always_comb begin
        inst_port.addr_ok = inst_acc;
        data_port.addr_ok = data_acc;
        inst_port.data_ok = pop & (head_id == ARB_ID_INST);
        data_port.data_ok = pop & (head_id == ARB_ID_DATA);
        inst_port.rdata   = '0;
        data_port.rdata   = '0;
        if (pop && head_id == ARB_ID_INST) begin
            inst_port.rdata = mem_port.rdata;
        end
        if (pop && head_id == ARB_ID_DATA) begin
            data_port.rdata = mem_port.rdata;
        end
    end

    // Count how many accepted data cycles the waiting instruction request has lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_cnt <= '0;
        end else if (!inst_port.req || inst_acc) begin
            starve_cnt <= '0;
        end else if (data_acc) begin
            starve_cnt <= sat_inc(starve_cnt, STARVE_MAX);
        end
    end

    mem_arb_id_fifo #(
        .DEPTH   (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push    (accept),
        .push_id (push_id),
        .pop     (pop),
        .head    (head_id),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A response with nothing outstanding is a downstream protocol error; it is dropped.
    always @(posedge clk) begin
        assert (!resetn || !(mem_port.data_ok && fifo_count == '0))
            else $warning("mem_data_ok with no outstanding request, response dropped");
    end

`ifdef MEM_ARB_PERF_EN
    // Wrapping event counters for accepted requests and contention cycles.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_inst_acc <= '0;
            perf_data_acc <= '0;
            perf_conflict <= '0;
        end else begin
            if (inst_acc) begin
                perf_inst_acc <= perf_inst_acc + 32'd1;
            end
            if (data_acc) begin
                perf_data_acc <= perf_data_acc + 32'd1;
            end
            if (inst_port.req && data_port.req) begin
                perf_conflict <= perf_conflict + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_mem_req_arbiter;
    import mem_req_arbiter_pkg::*;

    localparam int MAXO  = 4;
    localparam int LIMIT = 3;

    logic clk = 1'b0;
    logic resetn = 1'b1;

    mem_req_arbiter_if inst_bus ();
    mem_req_arbiter_if data_bus ();
    mem_req_arbiter_if mem_bus ();

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_inst_acc;
    logic [31:0] perf_data_acc;
    logic [31:0] perf_conflict;
`endif

    mem_req_arbiter #(
        .MAX_OUTSTANDING (MAXO),
        .STARVE_LIMIT    (LIMIT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .inst_port (inst_bus),
        .data_port (data_bus),
        .mem_port  (mem_bus)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_inst_acc (perf_inst_acc),
        .perf_data_acc (perf_data_acc),
        .perf_conflict (perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: owners of outstanding requests in issue order (0 inst, 1 data),
    // number of accepted data cycles the current inst request has lost, event counts.
    bit          owner_q [$];
    int          lost_cnt = 0;
    logic [31:0] m_inst_acc = 0;
    logic [31:0] m_data_acc = 0;
    logic [31:0] m_conflict = 0;
    bit          last_inst_acc;
    bit          last_data_acc;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, check the settled outputs, advance the model.
    task automatic applyStimulus(
        input logic        rst_val,
        input logic        ir,  input logic [31:0] ia,
        input logic        dr,  input logic        dwr, input logic [3:0] ds,
        input logic [31:0] da,  input logic [31:0] dw,
        input logic        maok, input logic mdok, input logic [31:0] mrd);
        bit   inst_win, any_req, exp_req, exp_acc, do_pop, owner;
        @(negedge clk);
        resetn         = rst_val;
        inst_bus.req   = ir;
        inst_bus.wr    = 1'b0;
        inst_bus.wstrb = 4'h0;
        inst_bus.addr  = ia;
        inst_bus.wdata = 32'h0;
        data_bus.req   = dr;
        data_bus.wr    = dwr;
        data_bus.wstrb = ds;
        data_bus.addr  = da;
        data_bus.wdata = dw;
        mem_bus.addr_ok = maok;
        mem_bus.data_ok = mdok;
        mem_bus.rdata   = mrd;
        if (!rst_val) begin
            owner_q.delete();
            lost_cnt   = 0;
            m_inst_acc = 0;
            m_data_acc = 0;
            m_conflict = 0;
        end
        #1;
        any_req  = ir || dr;
        inst_win = ir && (!dr || lost_cnt >= LIMIT);
        exp_req  = rst_val && any_req && (owner_q.size() < MAXO);
        exp_acc  = exp_req && maok;
        do_pop   = rst_val && mdok && (owner_q.size() > 0);
        owner    = (owner_q.size() > 0) ? owner_q[0] : 1'b0;

        checkOutput("mem_req",      mem_bus.req,       exp_req);
        checkOutput("inst_addr_ok", inst_bus.addr_ok,  exp_acc && inst_win);
        checkOutput("data_addr_ok", data_bus.addr_ok,  exp_acc && !inst_win);
        checkOutput("inst_data_ok", inst_bus.data_ok,  do_pop && !owner);
        checkOutput("data_data_ok", data_bus.data_ok,  do_pop && owner);
        checkOutput("inst_rdata",   inst_bus.rdata,    (do_pop && !owner) ? mrd : 32'h0);
        checkOutput("data_rdata",   data_bus.rdata,    (do_pop && owner) ? mrd : 32'h0);
        if (exp_req) begin
            checkOutput("mem_addr",  mem_bus.addr,  inst_win ? ia : da);
            checkOutput("mem_wr",    mem_bus.wr,    inst_win ? 1'b0 : dwr);
            checkOutput("mem_wstrb", mem_bus.wstrb, inst_win ? 4'h0 : ds);
            checkOutput("mem_wdata", mem_bus.wdata, inst_win ? 32'h0 : dw);
        end
`ifdef MEM_ARB_PERF_EN
        checkOutput("perf_inst_acc", perf_inst_acc, m_inst_acc);
        checkOutput("perf_data_acc", perf_data_acc, m_data_acc);
        checkOutput("perf_conflict", perf_conflict, m_conflict);
`endif

        last_inst_acc = exp_acc && inst_win;
        last_data_acc = exp_acc && !inst_win;
        if (rst_val) begin
            if (do_pop) void'(owner_q.pop_front());
            if (exp_acc) owner_q.push_back(inst_win ? 1'b0 : 1'b1);
            if (!ir || last_inst_acc) lost_cnt = 0;
            else if (last_data_acc && lost_cnt < LIMIT) lost_cnt++;
            if (last_inst_acc) m_inst_acc++;
            if (last_data_acc) m_data_acc++;
            if (ir && dr) m_conflict++;
        end
    endtask

    task automatic drainAll();
        while (owner_q.size() > 0) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, $urandom);
        end
    endtask

    bit          pi, pd, pdwr;
    logic [31:0] pia, pda, pdw;
    logic [3:0]  pds;

    initial begin
        $display("[TB] start");
        // Reset state, with requests held low.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single instruction fetch answered two cycles later.
        applyStimulus(1, 1, 32'h1c00_0000, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h0280_0c0c);

        // Both request every cycle: data wins three times, then inst is forced through.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 1, 32'h1c00_0040, 1, 0, 4'h0, 32'h0000_1000 + k * 4, 0, 1, 0, 0);
        end
        drainAll();

        // Fill to capacity, stall while full, then one response reopens the port.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, k[0], 32'h1c00_0100, 1, 0, 4'h0, 32'h0000_2000, 0, 1, 0, 0);
        end
        applyStimulus(1, 0, 0, 1, 1, 4'hf, 32'h0000_2004, 32'hdead_beef, 1, 1, 32'h1111);
        applyStimulus(1, 0, 0, 1, 1, 4'hf, 32'h0000_2004, 32'hdead_beef, 1, 0, 0);
        drainAll();

        // Issue D, I, D and check in-order steering of responses A, B, C.
        applyStimulus(1, 0, 0, 1, 0, 4'h0, 32'h0000_3000, 0, 1, 0, 0);
        applyStimulus(1, 1, 32'h1c00_0200, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 1, 4'h3, 32'h0000_3004, 32'h5555_aaaa, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hA);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hB);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hC);

        // Two outstanding, then push and pop together for long enough to wrap the pointers.
        applyStimulus(1, 1, 32'h1c00_0300, 0, 0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 4'h0, 32'h0000_4000, 0, 1, 0, 0);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1, k[0], 32'h1c00_0304, !k[0], 0, 4'h0, 32'h0000_4004, 0, 1, 1,
                          32'h7000_0000 + k);
        end
        drainAll();

        // Reset with three outstanding; responses arriving afterwards are ignored.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 0, 0, 1, 0, 4'h0, 32'h0000_5000, 0, 1, 0, 0);
        end
        applyStimulus(0, 1, 32'h1c00_0400, 1, 0, 4'h0, 32'h0000_5004, 0, 1, 1, 32'h9999);
        applyStimulus(0, 1, 32'h1c00_0400, 1, 0, 4'h0, 32'h0000_5004, 0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8888);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h7777);

        // Random traffic; each requester holds its request until accepted.
        pi = 0;
        pd = 0;
        for (int c = 0; c < 600; c++) begin
            if (!pi && $urandom_range(0, 2) != 0) begin
                pi  = 1;
                pia = $urandom & 32'hffff_fffc;
            end
            if (!pd && $urandom_range(0, 2) != 0) begin
                pd   = 1;
                pdwr = $urandom_range(0, 1);
                pds  = pdwr ? 4'($urandom_range(1, 15)) : 4'h0;
                pda  = $urandom;
                pdw  = $urandom;
            end
            applyStimulus(1, pi, pia, pd, pdwr, pds, pda, pdw,
                          $urandom_range(0, 3) != 0,
                          (owner_q.size() > 0) && ($urandom_range(0, 1) == 1),
                          $urandom);
            if (last_inst_acc) pi = 0;
            if (last_data_acc) pd = 0;
        end
        drainAll();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
